// File: rtl/std_ram_stream_reader_if.sv
// rtl/std_ram_stream_reader_if.sv - command, RAM read port and output stream bundle for std_ram_stream_reader
interface std_ram_stream_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  start_valid;
    logic                  start_ready;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   start_count;

    logic                  ram_enable;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data_out;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    logic                  busy;

    // Reader side: drives the RAM read port and the output stream, accepts commands
    modport master (
        input  start_valid, start_addr, start_count, ram_data_out, out_ready,
        output start_ready, ram_enable, ram_addr, out_valid, out_data, out_last, busy
    );

    // Environment side: command initiator, block RAM and stream consumer
    modport slave (
        output start_valid, start_addr, start_count, ram_data_out, out_ready,
        input  start_ready, ram_enable, ram_addr, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/std_ram_stream_reader.sv
// rtl/std_ram_stream_reader.sv - block RAM read DMA to valid/ready stream; optional abort via STD_RAM_STREAM_READER_ABORT_EN
module std_ram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic clk,
    input  logic rst,
`ifdef STD_RAM_STREAM_READER_ABORT_EN
    input  logic abort,
`endif
    std_ram_stream_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic                  out_valid_q;
    logic                  out_last_q;

    logic                  cmd_fire;
    logic                  beat_fire;
    logic                  issue;
    logic                  final_issue;
    logic                  abort_req;
    logic                  start_ready_c;
    logic                  busy_c;
    logic                  out_last_c;

`ifdef STD_RAM_STREAM_READER_ABORT_EN
    // Abort only matters while reads are still being issued
    assign abort_req = abort && (state == READ);
`else
    assign abort_req = 1'b0;
`endif

    assign cmd_fire    = bus.start_valid && start_ready_c;
    assign beat_fire   = out_valid_q && bus.out_ready;
    assign final_issue = issue && (remaining_q == (ADDR_WIDTH+1)'(1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_fire && (bus.start_count != '0)) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (abort_req) begin
                    // A pending beat that is not taken this cycle becomes the closing beat
                    state_nxt = (out_valid_q && !bus.out_ready) ? DRAIN : IDLE;
                end else if (final_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (beat_fire && out_last_q) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: reads are issued only when the output register can take the result
    always_comb begin
        start_ready_c = (state == IDLE);
        busy_c        = (state != IDLE);
        issue         = (state == READ) && !abort_req && (!out_valid_q || bus.out_ready);
        out_last_c    = out_last_q || (abort_req && out_valid_q);
    end

    assign bus.start_ready = start_ready_c;
    assign bus.busy        = busy_c;
    assign bus.ram_enable  = issue;
    assign bus.ram_addr    = addr_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = bus.ram_data_out;
    assign bus.out_last    = out_last_c;

    // Address/remaining counters: loaded on command, stepped on each issue
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
        end else if (cmd_fire) begin
            addr_q      <= bus.start_addr;
            remaining_q <= bus.start_count;
        end else if (issue) begin
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            remaining_q <= remaining_q - (ADDR_WIDTH+1)'(1);
        end else if (abort_req) begin
            remaining_q <= '0;
        end
    end

    // Output valid/last track the RAM read data, which the RAM holds while enable is low
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (issue) begin
            out_valid_q <= 1'b1;
            out_last_q  <= final_issue;
        end else if (beat_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (abort_req && out_valid_q) begin
            out_last_q  <= 1'b1;
        end
    end

endmodule
